// File: rtl/aes_pkg.sv
// Shared AES datapath types: column/state words, the column sequencer state set,
// and a column extraction helper (column 0 is the most significant word).
package aes_pkg;

    localparam int unsigned AES_COL_W    = 32;
    localparam int unsigned AES_NUM_COLS = 4;

    typedef logic [AES_COL_W-1:0]              aes_col_t;
    typedef logic [AES_NUM_COLS*AES_COL_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_WAIT,
        SEQ_DONE
    } col_seq_state_t;

    function automatic aes_col_t col_of(aes_state_t s, logic [1:0] i);
        aes_col_t c;
        case (i)
            2'd0:    c = s[127:96];
            2'd1:    c = s[95:64];
            2'd2:    c = s[63:32];
            default: c = s[31:0];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aes_col_extract.sv
// Combinational column selector: picks one COL_W-bit column out of the state,
// column 0 being the most significant word.
module aes_col_extract #(
    parameter int unsigned COL_W    = 32,
    parameter int unsigned NUM_COLS = 4
) (
    input  logic [NUM_COLS*COL_W-1:0]    state_i,
    input  logic [$clog2(NUM_COLS)-1:0]  idx_i,
    output logic [COL_W-1:0]             col_o
);

    localparam int unsigned IW = $clog2(NUM_COLS);

    always_comb begin
        col_o = '0;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            if (idx_i == IW'(c)) begin
                col_o = state_i[(NUM_COLS-1-c)*COL_W +: COL_W];
            end
        end
    end

endmodule

// File: rtl/aes_col_sequencer.sv
// Issues the four columns of a latched AES state to a column unit over valid/ready,
// writes each returned column back into its slot and pulses Done when all are back.
module aes_col_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned COL_W    = 32,
    parameter int unsigned NUM_COLS = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic [NUM_COLS*COL_W-1:0]    State_In,
    output logic [COL_W-1:0]             Col_Out,
    output logic [$clog2(NUM_COLS)-1:0]  Col_Idx,
    output logic                         Col_Valid,
    input  logic                         Col_Ready,
    input  logic [COL_W-1:0]             Ret_Col,
    input  logic                         Ret_Valid,
    output logic [NUM_COLS*COL_W-1:0]    State_Out,
    output logic                         Busy,
    output logic                         Done
);

    localparam int unsigned IW = $clog2(NUM_COLS);
    localparam int unsigned SW = NUM_COLS * COL_W;

    col_seq_state_t  state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [SW-1:0]   buf_q, buf_d;
    logic [SW-1:0]   out_q, out_d;
    logic [NUM_COLS-1:0] wr_en;

    aes_col_extract #(
        .COL_W    (COL_W),
        .NUM_COLS (NUM_COLS)
    ) u_extract (
        .state_i (buf_q),
        .idx_i   (idx_q),
        .col_o   (Col_Out)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        out_d   = out_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (Start) begin
                    state_d = SEQ_ISSUE;
                    idx_d   = '0;
                    buf_d   = State_In;
                    out_d   = State_In;
                end
            end
            SEQ_ISSUE: begin
                if (Col_Ready) state_d = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (Ret_Valid) begin
                    // the last column is terminal: leave through DONE instead of wrapping idx
                    if (idx_q == IW'(NUM_COLS-1)) begin
                        state_d = SEQ_DONE;
                    end else begin
                        state_d = SEQ_ISSUE;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            SEQ_DONE: state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase

        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            wr_en[c] = (state_q == SEQ_WAIT) && Ret_Valid && (idx_q == IW'(c));
            if (wr_en[c]) out_d[(NUM_COLS-1-c)*COL_W +: COL_W] = Ret_Col;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= SEQ_IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        Col_Idx   = idx_q;
        Col_Valid = (state_q == SEQ_ISSUE);
        Busy      = (state_q != SEQ_IDLE);
        Done      = (state_q == SEQ_DONE);
        State_Out = out_q;
    end

endmodule

// File: tb/tb_aes_col_sequencer.sv
// Directed bench for aes_col_sequencer: a step-count model of the column schedule
// plus literal expectations for the directed scenarios.
module tb_aes_col_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] sin = '0;
    logic         ready = 1'b0;
    logic         rvalid = 1'b0;
    logic [31:0]  rcol;
    logic [31:0]  Col_Out;
    logic [1:0]   Col_Idx;
    logic         Col_Valid, Busy, Done;
    logic [127:0] State_Out;

    logic         ret_inv = 1'b1;
    logic         ret_ovr = 1'b0;
    logic [31:0]  ret_fix = 32'hDEAD_BEEF;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    localparam logic [127:0] ST_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] ST_C = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    aes_col_sequencer #(.COL_W(32), .NUM_COLS(4)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .Start     (start),
        .State_In  (sin),
        .Col_Out   (Col_Out),
        .Col_Idx   (Col_Idx),
        .Col_Valid (Col_Valid),
        .Col_Ready (ready),
        .Ret_Col   (rcol),
        .Ret_Valid (rvalid),
        .State_Out (State_Out),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] colsel(input logic [127:0] s, input int c);
        logic [127:0] t;
        if (c < 0 || c > 3) return '0;
        t = s >> (32 * (3 - c));
        return t[31:0];
    endfunction

    function automatic logic [127:0] put(input logic [127:0] s, input int c, input logic [31:0] v);
        logic [127:0] m, w;
        m = {96'b0, 32'hFFFF_FFFF} << (32 * (3 - c));
        w = {96'b0, v} << (32 * (3 - c));
        return (s & ~m) | w;
    endfunction

    // step: -1 idle, 2k issuing column k, 2k+1 awaiting column k, 8 done
    int           step = -1;
    logic [127:0] m_buf = '0;
    logic [127:0] m_out = '0;

    always_comb rcol = ret_ovr ? ret_fix :
                       (ret_inv ? ~colsel(m_buf, step / 2) : colsel(m_buf, step / 2));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            step  <= -1;
            m_buf <= '0;
            m_out <= '0;
        end else if (step == -1) begin
            if (start) begin
                m_buf <= sin;
                m_out <= sin;
                step  <= 0;
            end
        end else if (step == 8) begin
            step <= -1;
        end else if (step % 2 == 0) begin
            if (ready) step <= step + 1;
        end else if (rvalid) begin
            m_out <= put(m_out, step / 2, rcol);
            step  <= step + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 128'(Busy), 128'(step >= 0));
            chk("done", 128'(Done), 128'(step == 8));
            chk("col_valid", 128'(Col_Valid), 128'(step >= 0 && step < 8 && step % 2 == 0));
            if (step >= 0 && step < 8) chk("col_idx", 128'(Col_Idx), 128'(step / 2));
            if (step >= 0 && step < 8 && step % 2 == 0) chk("col_out", 128'(Col_Out), 128'(colsel(m_buf, step / 2)));
            if (step == -1 || step == 8) chk("state_out", State_Out, m_out);
        end
    end

    logic [31:0] hs_col[$];
    logic [1:0]  hs_idx[$];
    always @(negedge clk) begin
        if (!rst && Col_Valid && ready) begin
            hs_col.push_back(Col_Out);
            hs_idx.push_back(Col_Idx);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [127:0] s, output int s0);
        sin   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        s0    = cyc;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (Done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 128'(seen), 128'(1));
    endtask

    task automatic wait_col(input string name, input logic [1:0] idx, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (Col_Valid && Col_Idx == idx) seen = 1'b1;
        end
        chk({name, "_col_seen"}, 128'(seen), 128'(1));
    endtask

    initial begin
        int s0, d1, d2;
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d1, d2;

        // reset state
        ready = 1'b1; rvalid = 1'b1; ret_inv = 1'b1; ret_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 128'(Busy), 128'(0));
        chk("rst_done", 128'(Done), 128'(0));
        chk("rst_valid", 128'(Col_Valid), 128'(0));
        chk("rst_state_out", State_Out, 128'(0));
        chk("rst_col_out", 128'(Col_Out), 128'(0));
        chk("rst_idx", 128'(Col_Idx), 128'(0));
        rst = 1'b0;
        tick();

        // 1: full-speed run, inverted return
        hs_col.delete(); hs_idx.delete();
        do_start(ST_A, s0);
        wait_done("t1", 40);
        chk("t1_latency", 128'(cyc - s0), 128'(8));
        chk("t1_state_out", State_Out, 128'hFFEEDDCC_BBAA9988_77665544_33221100);
        chk("t1_hs_count", 128'(hs_col.size()), 128'(4));
        if (hs_col.size() == 4) begin
            chk("t1_col0", 128'(hs_col[0]), 128'h00112233);
            chk("t1_col1", 128'(hs_col[1]), 128'h44556677);
            chk("t1_col2", 128'(hs_col[2]), 128'h8899AABB);
            chk("t1_col3", 128'(hs_col[3]), 128'hCCDDEEFF);
            chk("t1_idx3", 128'(hs_idx[3]), 128'(3));
        end
        tick();

        // 2: column 1 stalled five cycles by Col_Ready
        do_start(ST_A, s0);
        wait_col("t2", 2'd1, 20);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_stall_valid", 128'(Col_Valid), 128'(1));
            chk("t2_stall_col", 128'(Col_Out), 128'h44556677);
            chk("t2_stall_idx", 128'(Col_Idx), 128'(1));
        end
        ready = 1'b1;
        wait_done("t2", 40);
        chk("t2_latency", 128'(cyc - s0), 128'(13));
        tick();

        // 3: Ret_Valid during ISSUE (including the handshake cycle) is ignored
        ready = 1'b0; rvalid = 1'b1; ret_ovr = 1'b1;
        do_start(ST_A, s0);
        tick(); tick();
        ready = 1'b1;
        tick();
        ret_ovr = 1'b0;
        wait_done("t3", 40);
        chk("t3_col0", 128'(State_Out[127:96]), 128'hFFEEDDCC);
        chk("t3_state_out", State_Out, 128'hFFEEDDCC_BBAA9988_77665544_33221100);
        chk("t3_latency", 128'(cyc - s0), 128'(10));
        tick();

        // 4: Start re-asserted in WAIT is ignored
        ready = 1'b1; rvalid = 1'b0;
        do_start(ST_C, s0);
        tick();
        sin = '1; start = 1'b1;
        tick(); tick();
        chk("t4_busy", 128'(Busy), 128'(1));
        start = 1'b0; rvalid = 1'b1;
        wait_done("t4", 40);
        chk("t4_state_out", State_Out, 128'hFEDCBA98_76543210_01234567_89ABCDEF);
        tick();
        tick();
        chk("t4_idle_after", 128'(Busy), 128'(0));

        // 5: reset in WAIT on column 2, then a fresh run starts at column 0
        do_start(ST_A, s0);
        wait_col("t5", 2'd2, 20);
        rvalid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t5_busy", 128'(Busy), 128'(0));
        chk("t5_valid", 128'(Col_Valid), 128'(0));
        chk("t5_state_out", State_Out, 128'(0));
        chk("t5_done", 128'(Done), 128'(0));
        hs_col.delete(); hs_idx.delete();
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b1;
        tick();
        do_start(ST_C, s0);
        wait_done("t5", 40);
        chk("t5_first_idx", 128'(hs_idx.size() > 0 ? hs_idx[0] : 2'd3), 128'(0));
        chk("t5_first_col", 128'(hs_col.size() > 0 ? hs_col[0] : 32'h0), 128'h01234567);
        tick();

        // 6: back-to-back runs ten cycles apart, identity return
        ret_inv = 1'b0;
        tick();
        d1 = 0; d2 = 0;
        sin = ST_A; start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            if (k == 0) start = 1'b0;
            if (k == 9) begin sin = ST_C; start = 1'b1; end
            if (k == 10) start = 1'b0;
            @(negedge clk);
            if (Done) begin
                if (k < 10) begin
                    d1++;
                    chk("t6_run1_out", State_Out, ST_A);
                end else begin
                    d2++;
                    chk("t6_run2_out", State_Out, ST_C);
                end
            end
        end
        chk("t6_run1_dones", 128'(d1), 128'(1));
        chk("t6_run2_dones", 128'(d2), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
